// File: rtl/prsgen_mc_if.sv
// Level-write port for prsgen_mc: valid/ready handshake carrying a channel index and a level.
interface prsgen_mc_if #(
  parameter int unsigned WIDTH = 8
);
  logic             wr_valid;
  logic             wr_ready;
  logic [3:0]       wr_chan;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_chan, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_chan, input wr_data, output wr_ready);
endinterface

// File: rtl/prsgen_mc.sv
// prsgen_mc: multi-channel pseudo-random pulse-density generator.
// One shared Galois LFSR feeds CHANNELS comparators, each seeing a rotated copy
// of the LFSR word. Levels are written into shadow registers and committed when
// the LFSR passes its seed state, so the density never changes mid-period.
// Optional feature macro: PRSGEN_SIGMA_DELTA_EN adds per-channel first-order
// sigma-delta accumulators selected by mode=1.
module prsgen_mc #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                mode,
  prsgen_mc_if.slave          wr,
  output logic [CHANNELS-1:0] out,
  output logic                period_start
);

  // Maximal-length Galois feedback masks (top bit always set)
  function automatic logic [15:0] tap_mask(input int unsigned w);
    case (w)
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0E08;
      13:      tap_mask = 16'h1C80;
      14:      tap_mask = 16'h3802;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hB400;
      default: tap_mask = 16'h000C;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int unsigned s);
    return (v << s) | (v >> (WIDTH - s));
  endfunction

  localparam logic [15:0]      TAP_TABLE = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAP_TABLE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED      = WIDTH'(1);

  logic [WIDTH-1:0]    lfsr;
  logic [WIDTH-1:0]    lfsr_nxt;
  logic [WIDTH-1:0]    active [CHANNELS];
  logic [WIDTH-1:0]    shadow [CHANNELS];
  logic [CHANNELS-1:0] pending;
  logic [15:0]         pend_ext;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] out_nxt;
  logic                commit;

`ifdef PRSGEN_SIGMA_DELTA_EN
  logic [WIDTH-1:0] acc     [CHANNELS];
  logic [WIDTH-1:0] acc_nxt [CHANNELS];
  logic [WIDTH:0]   sd_sum  [CHANNELS];
`else
  logic mode_unused;
  assign mode_unused = mode;
`endif

  assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign commit   = enable && (lfsr == SEED);

  // Out-of-range channels read as never pending, so their writes are always accepted
  assign pend_ext    = 16'(pending);
  assign wr.wr_ready = !pend_ext[wr.wr_chan];

  // Per-channel write-accept decode
  always_comb begin
    wr_hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_hit[c] = wr.wr_valid && wr.wr_ready && (wr.wr_chan == 4'(c));
    end
  end

  // Next output bits: rotated-LFSR compare, or accumulator carry in sigma-delta mode
  always_comb begin
    out_nxt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      out_nxt[c] = (rotl(lfsr, (3 * c) % WIDTH) <= active[c]);
    end
`ifdef PRSGEN_SIGMA_DELTA_EN
    for (int c = 0; c < CHANNELS; c++) begin
      sd_sum[c]  = {1'b0, acc[c]} + {1'b0, active[c]};
      acc_nxt[c] = sd_sum[c][WIDTH-1:0];
      if (mode) out_nxt[c] = sd_sum[c][WIDTH];
    end
`endif
  end

  // LFSR, outputs and period marker; everything freezes while enable is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr         <= SEED;
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= commit;
      out          <= enable ? out_nxt : '0;
      if (enable) lfsr <= lfsr_nxt;
    end
  end

  // Shadow/pending/active level registers; commit sees pending from before this edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        active[c] <= '0;
        shadow[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (commit && pending[c]) begin
          active[c]  <= shadow[c];
          pending[c] <= 1'b0;
        end else if (wr_hit[c]) begin
          shadow[c]  <= wr.wr_data;
          pending[c] <= 1'b1;
        end
      end
    end
  end

`ifdef PRSGEN_SIGMA_DELTA_EN
  // Sigma-delta accumulators; kept across mode changes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else if (enable) begin
      for (int c = 0; c < CHANNELS; c++) acc[c] <= acc_nxt[c];
    end
  end
`endif

endmodule

// File: tb/tb_prsgen_mc.sv
// Self-checking bench for prsgen_mc: per-period high counts, period spacing,
// write handshake and reset behaviour against a level/pending model.
module tb_prsgen_mc;
  localparam int W      = 8;
  localparam int CH     = 4;
  localparam int PERIOD = (1 << W) - 1;
  localparam int BUDGET = 2 * PERIOD + 200;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic [CH-1:0] out;
  logic          period_start;

  prsgen_mc_if #(.WIDTH(W)) bus ();

  prsgen_mc #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mode         (mode),
    .wr           (bus.slave),
    .out          (out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: levels per channel, committed at each period boundary
  int m_shadow [16];
  int m_act    [16];
  bit m_pend   [16];
  int win_level[CH];
  int win_cnt  [CH];
  bit win_valid, fresh, have_pulse, sd_phase;
  int en_edges;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_shadow[i] = 0; m_act[i] = 0; m_pend[i] = 1'b0;
    end
    for (int c = 0; c < CH; c++) begin
      win_level[c] = 0; win_cnt[c] = 0;
    end
    win_valid = 1'b0; fresh = 1'b1; have_pulse = 1'b0; en_edges = 0;
  endfunction

  // Monitor: capture inputs before each edge, check outputs after it
  initial begin
    sd_phase = 1'b0;
    model_reset();
    forever begin
      bit pre_en, acc;
      int pch, pd, e;
      @(negedge clk); #4;
      if (!reset) begin model_reset(); continue; end
      pre_en = enable;
      pch    = int'(bus.wr_chan);
      pd     = int'(bus.wr_data);
      acc    = bus.wr_valid && bus.wr_ready;
      if (bus.wr_valid) begin
        e = (pch >= CH) ? 1 : (m_pend[pch] ? 0 : 1);
        check($sformatf("wr_ready_ch%0d", pch), bus.wr_ready, e);
      end
      @(posedge clk); #1;
      if (!reset) begin model_reset(); continue; end
      if (pre_en) en_edges++;
      else begin
        check("out_while_disabled", out, 0);
        check("pstart_while_disabled", period_start, 0);
      end
      if (fresh && pre_en) begin
        check("first_pulse_after_reset", period_start, 1);
        fresh = 1'b0;
      end
      for (int c = 0; c < CH; c++) win_cnt[c] += int'(out[c]);
      if (period_start) begin
        if (have_pulse) check("period_enabled_cycles", en_edges, PERIOD);
        have_pulse = 1'b1;
        en_edges   = 0;
        if (win_valid && !sd_phase)
          for (int c = 0; c < CH; c++)
            check($sformatf("window_count_ch%0d", c), win_cnt[c], win_level[c]);
        for (int i = 0; i < 16; i++)
          if (m_pend[i]) begin m_act[i] = m_shadow[i]; m_pend[i] = 1'b0; end
        for (int c = 0; c < CH; c++) begin
          win_level[c] = m_act[c]; win_cnt[c] = 0;
        end
        win_valid = 1'b1;
      end
      if (acc && pch < CH) begin
        m_shadow[pch] = pd; m_pend[pch] = 1'b1;
      end
    end
  end

  int meas[CH];
  int raw;

  task automatic sample();
    @(posedge clk); #1;
    raw++;
    for (int c = 0; c < CH; c++) meas[c] += int'(out[c]);
  endtask

  task automatic wait_pulse();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!period_start && n < BUDGET);
    if (!period_start) check("pulse_timeout", 0, 1);
  endtask

  // Count highs over one full window: after a pulse up to and including the next
  task automatic measure();
    wait_pulse();
    foreach (meas[c]) meas[c] = 0;
    raw = 0;
    do sample(); while (!period_start && raw < BUDGET);
    if (!period_start) check("measure_timeout", 0, 1);
  endtask

  task automatic do_write(input int ch, input int d);
    int n = 0;
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_chan = 4'(ch); bus.wr_data = W'(d);
    #4;
    while (!bus.wr_ready && n < BUDGET) begin @(negedge clk); #4; n++; end
    if (!bus.wr_ready) check("write_timeout", 0, 1);
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
  endtask

  typedef struct {
    int chan;
    int data;
    int exp_count;
  } wr_vec_t;

  wr_vec_t vecs[5];

  initial begin
    int ch, d;
    vecs[0] = '{0, 'h80, 128};
    vecs[1] = '{1, 'hFF, 255};
    vecs[2] = '{2, 'h00, 0};
    vecs[3] = '{7, 'h33, 0};
    vecs[4] = '{3, 'h01, 1};

    bus.wr_valid = 1'b0; bus.wr_chan = '0; bus.wr_data = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_out", out, 0);
    check("reset_pstart", period_start, 0);
    check("reset_wr_ready", bus.wr_ready, 1);
    @(negedge clk);
    reset = 1'b1; enable = 1'b1;
    repeat (2 * PERIOD + 10) @(negedge clk);

    // Table-driven levels, then one full window checked against expected counts
    for (int i = 0; i < 5; i++) do_write(vecs[i].chan, vecs[i].data);
    wait_pulse();
    measure();
    for (int i = 0; i < 5; i++)
      if (vecs[i].chan < CH)
        check($sformatf("table_ch%0d", vecs[i].chan), meas[vecs[i].chan], vecs[i].exp_count);

    // Mid-period write, then a second write to the same channel must stall
    wait_pulse();
    repeat (60) @(negedge clk);
    do_write(3, 'h40);
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_chan = 4'd3; bus.wr_data = W'(8'h10);
    #4 check("stall_ready_ch3", bus.wr_ready, 0);
    do_write(3, 'h10);
    measure();
    check("ch3_second_level", meas[3], 16);
    check("ch0_level_kept", meas[0], 128);

    // Enable drop of 50 cycles stretches the period but not the counts
    wait_pulse();
    foreach (meas[c]) meas[c] = 0;
    raw = 0;
    repeat (100) sample();
    enable = 1'b0;
    repeat (50) sample();
    enable = 1'b1;
    do sample(); while (!period_start && raw < BUDGET);
    check("stretched_period", raw, PERIOD + 50);
    check("stretch_ch0", meas[0], 128);
    check("stretch_ch1", meas[1], 255);
    check("stretch_ch3", meas[3], 16);

    // Reset mid-period with ch0 pending
    wait_pulse();
    repeat (30) @(negedge clk);
    do_write(0, 'h20);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("midrst_out", out, 0);
    check("midrst_pstart", period_start, 0);
    check("midrst_wr_ready", bus.wr_ready, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_seed_pulse", period_start, 1);
    measure();
    for (int c = 0; c < CH; c++) check($sformatf("midrst_discard_ch%0d", c), meas[c], 0);

    // Randomized writes, enable drops and (ignored) mode toggles
    for (int k = 0; k < 150; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
`ifndef PRSGEN_SIGMA_DELTA_EN
      mode = 1'($urandom_range(0, 1));
`endif
      if (r < 6) begin
        ch = int'($urandom_range(0, CH + 1));
        if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) != 0) ? PERIOD : 0;
        else d = int'($urandom_range(0, PERIOD));
        do_write(ch, d);
      end else if (r < 7) begin
        @(negedge clk); enable = 1'b0;
        repeat ($urandom_range(1, 30)) @(negedge clk);
        enable = 1'b1;
      end else begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
      end
    end
    mode = 1'b0;
    wait_pulse();
    wait_pulse();
    wait_pulse();

`ifdef PRSGEN_SIGMA_DELTA_EN
    sd_phase = 1'b1;
    do_write(0, 'h40);
    wait_pulse();
    wait_pulse();
    @(negedge clk);
    mode = 1'b1;
    repeat (8) sample();
    for (int g = 0; g < 16; g++) begin
      foreach (meas[c]) meas[c] = 0;
      repeat (4) sample();
      check("sd_one_in_four", meas[0], 1);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/prsgen_mc.md
# prsgen_mc

Parametrised multi-channel pseudo-random pulse-density generator, the successor to the 8-bit single-channel PRS generator. One shared maximal-length LFSR drives CHANNELS 1-bit outputs whose mean density equals each channel's programmed level. Levels are written through a valid/ready port and committed only at sequence-period boundaries, so the density seen by the co-simulated analog model never glitches mid-period. It sits between digital control logic and the analog filter/DAC model.

## Interface
- WIDTH, 8: level and LFSR width, legal 4..16.
- CHANNELS, 4: number of outputs, legal 1..16.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = run; 0 = freeze LFSR and accumulators, force out to 0.
- mode  in  1  0 = PRS compare; 1 = sigma-delta (only with PRSGEN_SIGMA_DELTA_EN, otherwise ignored).
- wr_valid  in  1  level write request.
- wr_ready  out  1  write can be accepted this cycle.
- wr_chan  in  4  target channel.
- wr_data  in  WIDTH  new level.
- out  out  CHANNELS  registered pulse-density outputs, bit c = channel c.
- period_start  out  1  one-cycle pulse when the LFSR is in its seed state.

## Operation
- LFSR: Galois, maximal-length taps per WIDTH (fixed table for 4..16), period 2^WIDTH-1, seed 1, never zero. Advances once per cycle while enable=1.
- Per-channel compare word r_c = LFSR rotated left by (3*c) mod WIDTH; rotation permutes the nonzero words, so each channel sees every value 1..2^WIDTH-1 once per period.
- PRS mode: out[c] <= (r_c <= active[c]). Exactly active[c] highs per period; 0 = never high, 2^WIDTH-1 = always high.
- Sigma-delta mode: {carry, acc[c]} = acc[c] + active[c] (WIDTH-bit wrap, modulo 2^WIDTH); out[c] <= carry. Density active[c]/2^WIDTH.
- Write port: per-channel shadow[c] and pending[c]. wr_ready = !pending[wr_chan], or 1 if wr_chan >= CHANNELS. Accept on rising edge with wr_valid && wr_ready: shadow <= wr_data, pending <= 1. Writes to wr_chan >= CHANNELS are accepted and dropped.
- Commit: on each cycle with LFSR == 1 and enable=1, for every pending channel active <= shadow, pending <= 0.
- Mode change takes effect next cycle; accumulators are not cleared on mode change.

## Timing
- Reset (asynchronous assert, synchronous-edge release): LFSR=1, active=0, shadow=0, pending=0, acc=0, out=0, period_start=0, wr_ready=1.
- out latency: one cycle from the LFSR/accumulator state it is computed from.
- period_start is registered and high the cycle after the LFSR holds 1: first pulse on the first edge after reset release with enable=1, then every 2^WIDTH-1 enabled cycles.
- Commit latency: a level written at cycle t first affects out on the cycle after the next commit edge. Worst case 2^WIDTH-1 cycles plus one.
- Write accepted on a commit edge: the commit uses the old pending state, so the new value waits for the following boundary. This only happens when pending was 0, because otherwise wr_ready was low.
- enable=0: all state held, out=0 on the next edge, no commits, writes still accepted. On re-enable the sequence resumes from the held state.
- Reset mid-period discards all pending and active levels.

## Configuration
- PRSGEN_SIGMA_DELTA_EN defined: accumulators and mode mux compiled in, mode selects as above.
- Undefined: no accumulators, mode input unused, PRS mode only, and behaviour is identical to mode=0.

## Test plan
- Reset, no writes, enable=1 -> out=0 on every channel; period_start first pulse 1 cycle after release, then every 255 cycles (WIDTH=8).
- Write ch0=0x80, ch1=0xFF, ch2=0x00 -> after commit, over 255 cycles: ch0 high exactly 128 times, ch1 always high, ch2 never high.
- Write ch3=0x40 mid-period -> ch3 unchanged until the cycle after the next period_start; second write to ch3 before commit sees wr_ready=0 and is stalled.
- Drop enable for 50 cycles -> out=0, period_start interval stretched by exactly 50 cycles, per-period high counts unchanged.
- Assert reset mid-period with ch0 pending -> all outputs 0, pending cleared, wr_ready=1, LFSR restarts at seed.
- With PRSGEN_SIGMA_DELTA_EN, mode=1, ch0=0x40 -> out[0] high exactly once every 4 cycles after the accumulators settle; WIDTH=12, CHANNELS=16 build passes the PRS count check (level 0x800 -> 2048 highs per 4095 cycles).
